// File: rtl/data_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_ram_if                                               |
// | Purpose  : Read/write bus bundle between a requester and data_ram.   |
// |            The master drives the enables, addresses, byte-lane       |
// |            selects and write word. The slave returns the read word.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface data_ram_if;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        write_enable;
  logic [31:0] write_address;
  logic [3:0]  write_select;
  logic [31:0] write_data;

  modport master (
    output read_enable, read_address,
    output write_enable, write_address, write_select, write_data,
    input  read_data
  );

  modport slave (
    input  read_enable, read_address,
    input  write_enable, write_address, write_select, write_data,
    output read_data
  );
endinterface
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_ram                                                  |
// | Purpose  : Word-organised RAM with byte-lane writes, a combinational |
// |            read port and a post-reset zero-fill sweep. It keeps      |
// |            saturating access counters and a sticky error flag that   |
// |            records the first bad access address.                     |
// | Ports    : clock         - rising-edge clock                         |
// |            reset         - asynchronous active-low reset             |
// |            bus           - data_ram_if slave (read/write bus)        |
// |            busy          - high while the clear sweep runs           |
// |            read_count    - accepted reads, saturating                |
// |            write_count   - accepted writes, saturating               |
// |            error         - sticky out-of-range/dropped access flag   |
// |            error_address - byte address of the first bad access      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module data_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic        clock,
  input  wire logic        reset,
  data_ram_if.slave        bus,
  output logic             busy,
  output logic [31:0]      read_count,
  output logic [31:0]      write_count,
  output logic             error,
  output logic [31:0]      error_address
);

  localparam int                    c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_word = '1;
  localparam logic [31:0]           c_count_max = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [31:0]           r_mem [c_depth];

  logic                  w_ready;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_rd_err;
  logic                  w_wr_err;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [ADDR_WIDTH-1:0] w_wr_idx;

  assign w_ready       = (r_state == READY);
  // Byte address bits above the word index must be zero.
  assign w_rd_in_range = ~|bus.read_address[31:ADDR_WIDTH+2];
  assign w_wr_in_range = ~|bus.write_address[31:ADDR_WIDTH+2];
  assign w_rd_idx      = bus.read_address[ADDR_WIDTH+1:2];
  assign w_wr_idx      = bus.write_address[ADDR_WIDTH+1:2];

  assign w_rd_ok  = bus.read_enable  & w_ready & w_rd_in_range;
  assign w_wr_ok  = bus.write_enable & w_ready & w_wr_in_range;
  // Any enabled access that is not accepted is an error (range or sweep).
  assign w_rd_err = bus.read_enable  & ~w_rd_ok;
  assign w_wr_err = bus.write_enable & ~w_wr_ok;

  // Combinational read sees the array before this edge's write commits,
  // so a same-cycle read of the written word returns the old value.
  assign bus.read_data = w_rd_ok ? r_mem[w_rd_idx] : 32'h0;

  // Array storage: no reset term, contents are only zeroed by the sweep.
  always_ff @(posedge clock) begin
    if (r_state == CLEAR) begin
      r_mem[r_sweep] <= 32'h0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.write_select[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
        end
      end
    end
  end

  // Sweep FSM with registered busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= CLEAR;
      r_sweep <= '0;
      busy    <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_sweep == c_last_word) begin
            r_state <= READY;
            r_sweep <= '0;
            busy    <= 1'b0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        default: begin
          r_state <= READY;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating access counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count  <= 32'h0;
      write_count <= 32'h0;
    end else begin
      if (w_rd_ok && (read_count != c_count_max)) begin
        read_count <= read_count + 32'd1;
      end
      if (w_wr_ok && (write_count != c_count_max)) begin
        write_count <= write_count + 32'd1;
      end
    end
  end

  // Sticky error; only the first failing access is recorded, and a
  // failing write takes priority over a failing read in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error         <= 1'b0;
      error_address <= 32'h0;
    end else if (w_rd_err || w_wr_err) begin
      error <= 1'b1;
      if (!error) begin
        error_address <= w_wr_err ? bus.write_address : bus.read_address;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_data_ram                                               |
// | Purpose  : Directed self-checking bench for data_ram. A behavioural  |
// |            model predicts memory, counters and error state; read     |
// |            expectations go through a scoreboard queue.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_data_ram;

  localparam int ADDR_WIDTH = 10;

  logic clock;
  logic reset;
  logic        busy;
  logic [31:0] read_count;
  logic [31:0] write_count;
  logic        error;
  logic [31:0] error_address;

  data_ram_if bus ();

  data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .busy          (busy),
    .read_count    (read_count),
    .write_count   (write_count),
    .error         (error),
    .error_address (error_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] model_mem [int];
  logic        exp_ready;
  logic [31:0] exp_rc;
  logic [31:0] exp_wc;
  logic        exp_err;
  logic [31:0] exp_ea;
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[ADDR_WIDTH+1:2]);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a[31:ADDR_WIDTH+2] == '0);
  endfunction

  // One bus cycle. Called just after a rising edge; returns just after the next.
  task automatic do_cycle(input logic re, input logic [31:0] ra,
                          input logic we, input logic [31:0] wa,
                          input logic [3:0] ws, input logic [31:0] wd,
                          input string tag);
    logic rok, wok, rerr, werr;
    logic [31:0] cur;
    int idx;
    rok  = re & exp_ready & in_range(ra);
    wok  = we & exp_ready & in_range(wa);
    rerr = re & ~rok;
    werr = we & ~wok;
    bus.read_enable   = re;
    bus.read_address  = ra;
    bus.write_enable  = we;
    bus.write_address = wa;
    bus.write_select  = ws;
    bus.write_data    = wd;
    if (re) sb_q.push_back(rok ? model_read(ra) : 32'h0);
    @(negedge clock);
    if (re) begin
      if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'h1, 32'h0);
      else                  check(tag, bus.read_data, sb_q.pop_front());
    end
    @(posedge clock);
    #1;
    if (wok) begin
      idx = int'(wa[ADDR_WIDTH+1:2]);
      cur = model_read(wa);
      for (int i = 0; i < 4; i++)
        if (ws[i]) cur[8*i +: 8] = wd[8*i +: 8];
      model_mem[idx] = cur;
    end
    if (rok && exp_rc != 32'hFFFF_FFFF) exp_rc = exp_rc + 1;
    if (wok && exp_wc != 32'hFFFF_FFFF) exp_wc = exp_wc + 1;
    if ((rerr || werr) && !exp_err) exp_ea = werr ? wa : ra;
    if (rerr || werr) exp_err = 1'b1;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"},  {31'h0, busy},  {31'h0, ~exp_ready});
    check({tag, "_rc"},    read_count,     exp_rc);
    check({tag, "_wc"},    write_count,    exp_wc);
    check({tag, "_err"},   {31'h0, error}, {31'h0, exp_err});
    check({tag, "_eaddr"}, error_address,  exp_ea);
  endtask

  // Assert reset for a few cycles; entered and left just after a rising edge.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    exp_ready = 1'b0;
    exp_rc = 0; exp_wc = 0; exp_err = 1'b0; exp_ea = 0;
    model_mem.delete();
    #1;
    check_status(tag);
    check({tag, "_rdata"}, bus.read_data, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy && cycles < 2000) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    exp_ready = 1'b1;
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    bus.read_enable = 1'b0;  bus.read_address = 0;
    bus.write_enable = 1'b0; bus.write_address = 0;
    bus.write_select = 0;    bus.write_data = 0;
    @(posedge clock);
    #1;

    // Reset state, with a read requested while in reset
    bus.read_enable = 1'b1;
    apply_reset("rst0");
    bus.read_enable = 1'b0;

    // Write during the sweep is dropped and flagged
    repeat (5) @(posedge clock);
    #1;
    do_cycle(1'b0, 0, 1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF, "busy_wr");
    wait_sweep(cyc);
    check_status("after_busy_wr");
    do_cycle(1'b1, 32'h10, 1'b0, 0, 0, 0, "busy_wr_rd");

    // Reset mid-operation, then measure a clean sweep
    apply_reset("rst1");
    wait_sweep(cyc);
    check("sweep_cycles", cyc, 1024);
    do_cycle(1'b1, 32'hFFC, 1'b0, 0, 0, 0, "rd_top_zero");

    // Byte-lane writes, unaligned address bits ignored
    do_cycle(1'b0, 0, 1'b1, 32'h40, 4'b1111, 32'h1122_3344, "wr_full");
    do_cycle(1'b0, 0, 1'b1, 32'h43, 4'b0101, 32'hAABB_CCDD, "wr_lanes");
    do_cycle(1'b1, 32'h40, 1'b0, 0, 0, 0, "rd_lanes");
    check("rd_lanes_const", model_read(32'h40), 32'h11BB_33DD);
    check_status("lanes");

    // Same-cycle read/write returns old data, next read returns new
    do_cycle(1'b0, 0, 1'b1, 32'h8, 4'hF, 32'h0102_0304, "wr_old");
    do_cycle(1'b1, 32'h8, 1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF, "rw_same");
    do_cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, "rd_new");
    check_status("rw");

    // Zero select: counted, no data change
    do_cycle(1'b0, 0, 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, "wr_sel0");
    do_cycle(1'b1, 32'h40, 1'b0, 0, 0, 0, "rd_sel0");
    check_status("sel0");

    // Out-of-range read, then a later bad write keeps the first address
    do_cycle(1'b1, 32'h0000_1000, 1'b0, 0, 0, 0, "rd_oor");
    check_status("oor_rd");
    do_cycle(1'b0, 0, 1'b1, 32'h0000_2000, 4'hF, 32'h5555_5555, "wr_oor");
    check_status("oor_wr");

    // Read counter saturation
    @(negedge clock);
    force dut.read_count = 32'hFFFF_FFFE;
    #1;
    release dut.read_count;
    @(posedge clock);
    #1;
    exp_rc = 32'hFFFF_FFFE;
    do_cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, "sat_rd1");
    do_cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, "sat_rd2");
    check("sat_rc", read_count, 32'hFFFF_FFFF);
    check_status("sat");

    // Reset again; simultaneous bad read and write during the sweep
    apply_reset("rst2");
    do_cycle(1'b1, 32'h100, 1'b1, 32'h200, 4'hF, 32'h1234_5678, "dual_err");
    check_status("dual_err");
    wait_sweep(cyc);
    do_cycle(1'b1, 32'h200, 1'b0, 0, 0, 0, "dual_err_rd");

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
